// File: rtl/lcd_fb_bank_sched.sv
// lcd_fb_bank_sched: triple-buffer bank scheduler for the LCD frame buffer.
// It takes the PPU pixel stream, issues per-pixel write bank/address, passes
// completed frames to the video-side reader and synthesises blank frames
// while the LCD is off.
// Optional feature macro: LCD_FB_STATS_EN adds the drop_cnt/rep_cnt outputs.
// H_VIS/V_VIS give the visible area written in blank mode. FRAME_PIX must
// equal H_VIS*V_VIS.
module lcd_fb_bank_sched #(
  parameter int FRAME_PIX = 23040,
  parameter int LINE_CYC  = 456,
  parameter int FRAME_LN  = 154,
  parameter int H_VIS     = 160,
  parameter int V_VIS     = 144
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        lcd_on,
  input  logic        lcd_vs,
  input  logic        wr_frame_end,
  input  logic        wr_pix,
  output logic        fb_we,
  output logic [1:0]  fb_bank,
  output logic [14:0] fb_addr,
  output logic        fb_blank,
  input  logic        rd_frame_req,
  output logic [1:0]  rd_bank,
  output logic        rd_new,
`ifdef LCD_FB_STATS_EN
  output logic [7:0]  drop_cnt,
  output logic [7:0]  rep_cnt,
`endif
  output logic        overrun
);

  localparam logic [1:0] ST_NORMAL  = 2'd0;
  localparam logic [1:0] ST_BLANK   = 2'd1;
  localparam logic [1:0] ST_WAIT_VS = 2'd2;

  localparam logic [14:0] PIX_FULL = 15'(FRAME_PIX);

  logic [1:0]  state;
  logic        lcd_on_q;
  logic        lcd_vs_q;
  logic [8:0]  h_cnt;
  logic [7:0]  v_cnt;
  logic [14:0] pix_cnt;
  logic [1:0]  rdy_bank;
  logic        rdy_valid;

  logic        lcd_fall, lcd_rise, vs_rise;
  logic        in_blank, enter_blank, go_normal;
  logic        blank_wrap, blank_wr, pix_wr;
  logic        frame_end, frame_ok, swap;
  logic [1:0]  rd_bank_nx;

  // Decode edges, write qualifiers and the frame-end / reader-swap events.
  always_comb begin
    lcd_fall    = lcd_on_q & ~lcd_on;
    lcd_rise    = ~lcd_on_q & lcd_on;
    vs_rise     = ~lcd_vs_q & lcd_vs;
    in_blank    = (state != ST_NORMAL);
    enter_blank = (state == ST_NORMAL) & lcd_fall;
    go_normal   = (state == ST_WAIT_VS) & vs_rise & ~lcd_fall;
    blank_wrap  = in_blank & ce & (h_cnt == 9'(LINE_CYC - 1)) & (v_cnt == 8'(FRAME_LN - 1));
    blank_wr    = in_blank & ce & (h_cnt < 9'(H_VIS)) & (v_cnt < 8'(V_VIS));
    pix_wr      = ~in_blank & ce & wr_pix & ~enter_blank;
    frame_end   = (~in_blank & wr_frame_end & ~enter_blank) | blank_wrap;
    frame_ok    = frame_end & (pix_cnt == PIX_FULL);
    swap        = rd_frame_req & rdy_valid;
    // The writer's next bank is chosen against the reader's post-swap bank.
    rd_bank_nx  = swap ? rdy_bank : rd_bank;
  end

  // Mode FSM plus the registered copies of lcd_on / lcd_vs for edge detection.
  // NOTE: all sequential state uses non-blocking assignments so every block
  // samples the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= ST_NORMAL;
      lcd_on_q <= 1'b0;
      lcd_vs_q <= 1'b0;
    end else begin
      lcd_on_q <= lcd_on;
      lcd_vs_q <= lcd_vs;
      case (state)
        ST_NORMAL:  if (lcd_fall) state <= ST_BLANK;
        ST_BLANK:   if (lcd_rise) state <= ST_WAIT_VS;
        ST_WAIT_VS: begin
          if (lcd_fall)     state <= ST_BLANK;
          else if (vs_rise) state <= ST_NORMAL;
        end
        default:    state <= ST_NORMAL;
      endcase
    end
  end

  // Blank-mode dot/line counters; restart only on entry from NORMAL.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (enter_blank) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (in_blank && ce) begin
      if (h_cnt == 9'(LINE_CYC - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == 8'(FRAME_LN - 1)) ? '0 : v_cnt + 8'd1;
      end else begin
        h_cnt <= h_cnt + 9'd1;
      end
    end
  end

  // Write path: one-cycle registered strobe/address, pixel counter, overrun flag.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_blank <= 1'b0;
      pix_cnt  <= '0;
      overrun  <= 1'b0;
    end else begin
      fb_we <= 1'b0;
      if (blank_wr || pix_wr) begin
        if (pix_cnt < PIX_FULL) begin
          fb_we    <= 1'b1;
          fb_addr  <= pix_cnt;
          fb_blank <= blank_wr;
          pix_cnt  <= pix_cnt + 15'd1;
        end else if (pix_wr) begin
          overrun <= 1'b1;
        end
      end
      // Any frame boundary or mode change restarts addressing at pixel 0.
      if (frame_end || enter_blank || go_normal) pix_cnt <= '0;
    end
  end

  // Bank rotation between writer, ready slot and reader.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fb_bank   <= 2'd0;
      rdy_bank  <= 2'd1;
      rdy_valid <= 1'b0;
      rd_bank   <= 2'd2;
      rd_new    <= 1'b0;
    end else begin
      rd_new  <= swap;
      rd_bank <= rd_bank_nx;
      if (swap) rdy_valid <= 1'b0;
      if (frame_ok) begin
        rdy_bank  <= fb_bank;
        rdy_valid <= 1'b1;
        // Banks are 0..2, so the third bank is 3 minus the other two.
        fb_bank   <= 2'd3 - rd_bank_nx - fb_bank;
      end
    end
  end

`ifdef LCD_FB_STATS_EN
  // Saturating counters for discarded frames and repeated reader frames.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      if (frame_end && !frame_ok && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (rd_frame_req && !rdy_valid && rep_cnt != 8'hFF) rep_cnt <= rep_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_fb_bank_sched.sv
// Directed bench for lcd_fb_bank_sched using a reduced frame geometry
// (8x4 visible, 12x6 total) so whole frames stay short.
module tb_lcd_fb_bank_sched;

  localparam int FP = 32;
  localparam int LC = 12;
  localparam int FL = 6;

  logic        clk_sys = 1'b0;
  logic        reset, ce, lcd_on, lcd_vs, wr_frame_end, wr_pix, rd_frame_req;
  logic        fb_we, fb_blank, rd_new, overrun;
  logic [1:0]  fb_bank, rd_bank;
  logic [14:0] fb_addr;
`ifdef LCD_FB_STATS_EN
  logic [7:0]  drop_cnt, rep_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int wcnt, blank_seen, nonblank_seen;
  logic [14:0] first_addr, last_addr;

  lcd_fb_bank_sched #(
    .FRAME_PIX(FP), .LINE_CYC(LC), .FRAME_LN(FL), .H_VIS(8), .V_VIS(4)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .lcd_on(lcd_on), .lcd_vs(lcd_vs),
    .wr_frame_end(wr_frame_end), .wr_pix(wr_pix),
    .fb_we(fb_we), .fb_bank(fb_bank), .fb_addr(fb_addr), .fb_blank(fb_blank),
    .rd_frame_req(rd_frame_req), .rd_bank(rd_bank), .rd_new(rd_new),
`ifdef LCD_FB_STATS_EN
    .drop_cnt(drop_cnt), .rep_cnt(rep_cnt),
`endif
    .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Drive n consecutive pixels and tally the resulting write strobes.
  task automatic send_pix(input int n);
    wcnt = 0; blank_seen = 0;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i <= n; i++) begin
      wr_pix = (i < n);
      tick();
      if (fb_we) begin
        if (wcnt == 0) first_addr = fb_addr;
        last_addr = fb_addr;
        wcnt++;
        if (fb_blank) blank_seen++;
      end
    end
    wr_pix = 1'b0;
  endtask

  task automatic pulse_fe();
    wr_frame_end = 1'b1; tick(); wr_frame_end = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_frame_req = 1'b1; tick(); rd_frame_req = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_fb_we"},    32'(fb_we),    32'd0);
    check({tag, "_fb_bank"},  32'(fb_bank),  32'd0);
    check({tag, "_fb_addr"},  32'(fb_addr),  32'd0);
    check({tag, "_fb_blank"}, 32'(fb_blank), 32'd0);
    check({tag, "_rd_bank"},  32'(rd_bank),  32'd2);
    check({tag, "_rd_new"},   32'(rd_new),   32'd0);
    check({tag, "_overrun"},  32'(overrun),  32'd0);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; lcd_on = 1'b1; lcd_vs = 1'b0;
    wr_frame_end = 1'b0; wr_pix = 1'b0; rd_frame_req = 1'b0;
    tick(); tick();
    check_reset_vals("rst");
`ifdef LCD_FB_STATS_EN
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_rep",  32'(rep_cnt),  32'd0);
`endif
    reset = 1'b0;
    tick();

    // First complete frame into bank 0; reader then takes it.
    send_pix(FP);
    check("f1_wcnt",  32'(wcnt),       32'(FP));
    check("f1_first", 32'(first_addr), 32'd0);
    check("f1_last",  32'(last_addr),  32'(FP - 1));
    check("f1_blank", 32'(blank_seen), 32'd0);
    pulse_fe();
    check("f1_fb_bank", 32'(fb_bank), 32'd1);
    check("f1_rd_hold", 32'(rd_bank), 32'd2);
    pulse_rd();
    check("f1_rd_bank", 32'(rd_bank), 32'd0);
    check("f1_rd_new",  32'(rd_new),  32'd1);
    tick();
    check("f1_rd_new_drop", 32'(rd_new), 32'd0);

    // Short frame is discarded; reader repeats its frame.
    send_pix(20);
    pulse_fe();
    check("drop_fb_bank", 32'(fb_bank), 32'd1);
    pulse_rd();
    check("drop_rd_bank", 32'(rd_bank), 32'd0);
    check("drop_rd_new",  32'(rd_new),  32'd0);
`ifdef LCD_FB_STATS_EN
    check("drop_cnt", 32'(drop_cnt), 32'd1);
    check("rep_cnt",  32'(rep_cnt),  32'd1);
`endif

    // Two complete frames with no request: the second replaces the first.
    send_pix(FP); pulse_fe();
    check("two_a_fb_bank", 32'(fb_bank), 32'd2);
    send_pix(FP); pulse_fe();
    check("two_b_fb_bank", 32'(fb_bank), 32'd1);
    pulse_rd();
    check("two_rd_bank", 32'(rd_bank), 32'd2);
    check("two_rd_new",  32'(rd_new),  32'd1);

    // Simultaneous request and frame end: reader gets old ready bank 1.
    send_pix(FP); pulse_fe();
    check("sim_pre_fb_bank", 32'(fb_bank), 32'd0);
    send_pix(FP);
    wr_frame_end = 1'b1; rd_frame_req = 1'b1;
    tick();
    wr_frame_end = 1'b0; rd_frame_req = 1'b0;
    check("sim_rd_bank", 32'(rd_bank), 32'd1);
    check("sim_fb_bank", 32'(fb_bank), 32'd2);
    check("sim_rd_new",  32'(rd_new),  32'd1);
    check("sim_distinct", 32'(rd_bank != fb_bank), 32'd1);
    pulse_rd();
    check("sim_rd_bank2", 32'(rd_bank), 32'd0);
    check("sim_fb_bank2", 32'(fb_bank), 32'd2);

    // LCD off: one synthetic blank frame, PPU pixels ignored throughout.
    lcd_on = 1'b0;
    tick();
    wr_pix = 1'b1;
    wcnt = 0; nonblank_seen = 0;
    for (int i = 0; i < LC * FL; i++) begin
      tick();
      if (fb_we) begin
        wcnt++;
        if (!fb_blank) nonblank_seen++;
      end
    end
    check("blank_wcnt",     32'(wcnt),          32'(FP));
    check("blank_nonblank", 32'(nonblank_seen), 32'd0);
    check("blank_fb_bank",  32'(fb_bank),       32'd1);
    lcd_on = 1'b1;
    tick();
    check("wait_we",    32'(fb_we),    32'd1);
    check("wait_blank", 32'(fb_blank), 32'd1);
    lcd_vs = 1'b1;
    tick();
    check("vs_we", 32'(fb_we), 32'd1);
    wr_pix = 1'b0; lcd_vs = 1'b0;
    tick();
    check("normal_idle_we", 32'(fb_we), 32'd0);
    send_pix(FP);
    check("norm_wcnt",  32'(wcnt),       32'(FP));
    check("norm_first", 32'(first_addr), 32'd0);
    check("norm_blank", 32'(blank_seen), 32'd0);
    pulse_fe();
    check("norm_fb_bank", 32'(fb_bank), 32'd2);
    pulse_rd();
    check("norm_rd_bank", 32'(rd_bank), 32'd1);

    // Overrun on the pixel past a full frame.
    send_pix(FP);
    check("ovr_before", 32'(overrun), 32'd0);
    send_pix(1);
    check("ovr_no_we", 32'(wcnt),    32'd0);
    check("ovr_flag",  32'(overrun), 32'd1);
    pulse_fe();
    check("ovr_fb_bank", 32'(fb_bank), 32'd0);

    // Reset in the middle of a frame returns everything to reset values.
    send_pix(5);
    reset = 1'b1;
    #2;
    check_reset_vals("mid");
    tick();
    reset = 1'b0;
    tick();
    pulse_rd();
    check("mid_rd_bank", 32'(rd_bank), 32'd2);
    check("mid_rd_new",  32'(rd_new),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
